lavadora_programavel: RTL and testbench
=======================================

LAVADORA_PROGRAMAVEL -- requirements
Module: lavadora_programavel

Interface
REQ-001 SHALL have parameter N_CICLOS, default 2, number of fill/agitate/drain cycles (1..15).
REQ-002 SHALL have parameter TIMER_W, default 8, timer width in bits.
REQ-003 SHALL have parameter T_AGITAR, default 20, agitate duration in clocks (1..2^TIMER_W).
REQ-004 SHALL have parameter T_GIRAR, default 10, spin duration in clocks (1..2^TIMER_W).
REQ-005 SHALL have port clock  input  1  system clock, rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port inicio  input  1  start request.
REQ-008 SHALL have port cheio  input  1  drum-full sensor.
REQ-009 SHALL have port vazio  input  1  drum-empty sensor.
REQ-010 SHALL have port secar  input  1  spin requested after last drain.
REQ-011 SHALL have port pausa  input  1  pause request.
REQ-012 SHALL have port valvula_agua  output  1  water inlet valve.
REQ-013 SHALL have port valvula_dreno  output  1  drain valve.
REQ-014 SHALL have port modo_agitar  output  1  agitate motor.
REQ-015 SHALL have port modo_girar  output  1  spin motor.
REQ-016 SHALL have port trava_porta  output  1  door lock.
REQ-017 SHALL have port concluido  output  1  one-clock completion pulse.
REQ-018 SHALL have port estado_atual  output  3  current state code.
REQ-019 SHALL have port ciclo_atual  output  4  zero-based index of the current cycle.

Function
REQ-020 SHALL implement states ESPERAR=0, ENCHER=1, AGITAR=2, DRENAR=3, GIRAR=4, FIM=5. Codes 6-7 SHALL go to ESPERAR on the next clock.
REQ-021 ESPERAR: inicio=1 -> ENCHER, ciclo_atual<=0.
REQ-022 ENCHER: cheio=1 -> AGITAR, timer<=T_AGITAR-1.
REQ-023 AGITAR: timer decrements each clock; timer==0 -> DRENAR, so AGITAR lasts exactly T_AGITAR clocks when not paused.
REQ-024 DRENAR: vazio=1 with ciclo_atual<N_CICLOS-1 -> ENCHER, ciclo_atual+1.
REQ-025 DRENAR: vazio=1 with ciclo_atual=N_CICLOS-1 and secar=1 -> GIRAR, timer<=T_GIRAR-1. With secar=0 -> FIM.
REQ-026 GIRAR: timer decrements each clock; timer==0 -> FIM.
REQ-027 FIM: concluido=1 for this one state clock, then -> ESPERAR unconditionally.
REQ-028 Outputs SHALL be Moore-decoded from state:
- valvula_agua=1 only in ENCHER.
- modo_agitar=1 only in AGITAR.
- valvula_dreno=1 only in DRENAR.
- modo_girar=1 only in GIRAR.
- trava_porta=1 in every state except ESPERAR.
REQ-029 inicio outside ESPERAR, cheio outside ENCHER, and vazio/secar outside DRENAR SHALL be ignored.
REQ-030 If cheio and vazio are both 1, only the sensor relevant to the current state SHALL be used.

Reset
REQ-031 reset_n=0 SHALL set, asynchronously and at any point mid-operation:
- state to ESPERAR.
- timer and ciclo_atual to 0.
- the pause freeze cleared.
- all outputs to 0 (estado_atual=0).
REQ-032 The first transition after reset release SHALL need inicio=1 at a rising edge.

Configuration
REQ-033 Macro LAVADORA_PAUSA_EN defined: in any state other than ESPERAR/FIM, pausa=1 SHALL freeze state, timer and ciclo_atual. While frozen, valvula_agua, valvula_dreno, modo_agitar and modo_girar SHALL be forced to 0 combinationally and trava_porta SHALL stay 1. Operation SHALL resume in the same state with the same timer value on the first clock with pausa=0.
REQ-034 Pause SHALL take priority over every transition condition.
REQ-035 Macro LAVADORA_PAUSA_EN undefined: port pausa SHALL remain present but be ignored, and no pause logic SHALL be synthesised.

Structure
REQ-036 Package lavadora_pkg SHALL hold typedef estado_t (3-bit enum, codes of REQ-020) and the state constants.
REQ-037 Sub-module temporizador (loadable TIMER_W-bit down counter with enable and zero flag) SHALL implement the timer. One instance SHALL serve both AGITAR and GIRAR.

Verification (N_CICLOS=2, T_AGITAR=4, T_GIRAR=3)
REQ-038 Full run: inicio, cheio, vazio, cheio, vazio, secar=1 -> state sequence 0,1,2x4,3,1,2x4,3,4x3,5,0; concluido high exactly 1 clock; ciclo_atual 0 then 1.
REQ-039 secar=0 at final drain -> DRENAR->FIM->ESPERAR, modo_girar never 1.
REQ-040 pausa=1 for 5 clocks at AGITAR clock 2 (macro defined) -> modo_agitar=0 and trava_porta=1 during the pause; AGITAR totals 4 active clocks plus 5 paused.
REQ-041 reset_n low mid-GIRAR -> immediately estado_atual=0, all outputs 0, ciclo_atual=0; inicio held during ENCHER has no effect.
REQ-042 Macro undefined, pausa=1 throughout the full run -> identical trace to REQ-038.

Source files
------------

// File: rtl/lavadora_pkg.sv
// Shared types for the programmable washer: state encoding and decoded output bundle.
package lavadora_pkg;

   localparam int unsigned ESTADO_W = 3;
   localparam int unsigned CICLO_W  = 4;

   typedef enum logic [ESTADO_W-1:0] {
      ESPERAR = 3'd0,
      ENCHER  = 3'd1,
      AGITAR  = 3'd2,
      DRENAR  = 3'd3,
      GIRAR   = 3'd4,
      FIM     = 3'd5
   } estado_t;

   typedef struct packed {
      logic valvula_agua;
      logic valvula_dreno;
      logic modo_agitar;
      logic modo_girar;
      logic trava_porta;
      logic concluido;
   } saidas_t;

   // Moore decode of the actuator outputs for a given state
   function automatic saidas_t decodificar(estado_t e);
      saidas_t s;
      s = '0;
      case (e)
         ENCHER:  s.valvula_agua  = 1'b1;
         AGITAR:  s.modo_agitar   = 1'b1;
         DRENAR:  s.valvula_dreno = 1'b1;
         GIRAR:   s.modo_girar    = 1'b1;
         FIM:     s.concluido     = 1'b1;
         default: s = '0;
      endcase
      s.trava_porta = (e != ESPERAR);
      return s;
   endfunction

endpackage

// File: rtl/lavadora_programavel_temporizador.sv
// Loadable down counter with enable; zero flag shared by the agitate and spin phases.
module temporizador #(
   parameter int unsigned TIMER_W = 8
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               carregar,
   input  logic [TIMER_W-1:0] valor,
   input  logic               habilitar,
   output logic               zero_c
);

   logic [TIMER_W-1:0] contagem;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         contagem <= '0;
      end else if (carregar) begin
         contagem <= valor;
      end else if (habilitar && (contagem != '0)) begin
         contagem <= contagem - TIMER_W'(1);
      end
   end

   assign zero_c = (contagem == '0);

endmodule

// File: rtl/lavadora_programavel.sv
// Programmable washer controller: fill/agitate/drain cycles with optional final spin.
// Define LAVADORA_PAUSA_EN to build the pause/freeze feature; otherwise pausa is ignored.
module lavadora_programavel
   import lavadora_pkg::*;
#(
   parameter int unsigned N_CICLOS = 2,
   parameter int unsigned TIMER_W  = 8,
   parameter int unsigned T_AGITAR = 20,
   parameter int unsigned T_GIRAR  = 10
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       inicio,
   input  logic       cheio,
   input  logic       vazio,
   input  logic       secar,
   input  logic       pausa,
   output logic       valvula_agua,
   output logic       valvula_dreno,
   output logic       modo_agitar,
   output logic       modo_girar,
   output logic       trava_porta,
   output logic       concluido,
   output logic [2:0] estado_atual,
   output logic [3:0] ciclo_atual
);

   localparam logic [CICLO_W-1:0] ULTIMO_CICLO = CICLO_W'(N_CICLOS - 1);
   localparam logic [TIMER_W-1:0] CARGA_AGITAR = TIMER_W'(T_AGITAR - 1);
   localparam logic [TIMER_W-1:0] CARGA_GIRAR  = TIMER_W'(T_GIRAR - 1);

   estado_t              estado;
   estado_t              estado_n;
   logic [CICLO_W-1:0]   ciclo;
   logic [CICLO_W-1:0]   ciclo_n;
   saidas_t              saidas_r;
   logic                 carregar_c;
   logic [TIMER_W-1:0]   valor_c;
   logic                 habilitar_c;
   logic                 zero_c;
   logic                 congelado_c;

`ifdef LAVADORA_PAUSA_EN
   // Freeze only while a wash is in progress; ESPERAR and FIM never hold
   assign congelado_c = pausa && (estado != ESPERAR) && (estado != FIM);
`else
   logic unused_pausa;
   assign unused_pausa = pausa;
   assign congelado_c  = 1'b0;
`endif

   temporizador #(
      .TIMER_W (TIMER_W)
   ) u_temporizador (
      .clock     (clock),
      .reset_n   (reset_n),
      .carregar  (carregar_c),
      .valor     (valor_c),
      .habilitar (habilitar_c),
      .zero_c    (zero_c)
   );

   // Next-state, cycle index and timer control; sensors are only looked at in their own state
   always_comb begin
      estado_n    = estado;
      ciclo_n     = ciclo;
      carregar_c  = 1'b0;
      valor_c     = '0;
      habilitar_c = 1'b0;
      if (!congelado_c) begin
         case (estado)
            ESPERAR: begin
               if (inicio) begin
                  estado_n = ENCHER;
                  ciclo_n  = '0;
               end
            end
            ENCHER: begin
               if (cheio) begin
                  estado_n   = AGITAR;
                  carregar_c = 1'b1;
                  valor_c    = CARGA_AGITAR;
               end
            end
            AGITAR: begin
               if (zero_c) estado_n = DRENAR;
               else        habilitar_c = 1'b1;
            end
            DRENAR: begin
               if (vazio) begin
                  if (ciclo < ULTIMO_CICLO) begin
                     estado_n = ENCHER;
                     ciclo_n  = ciclo + CICLO_W'(1);
                  end else if (secar) begin
                     estado_n   = GIRAR;
                     carregar_c = 1'b1;
                     valor_c    = CARGA_GIRAR;
                  end else begin
                     estado_n = FIM;
                  end
               end
            end
            GIRAR: begin
               if (zero_c) estado_n = FIM;
               else        habilitar_c = 1'b1;
            end
            FIM:     estado_n = ESPERAR;
            default: estado_n = ESPERAR;
         endcase
      end
   end

   // Outputs are decoded from the next state so they change on the same edge as the state
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         estado   <= ESPERAR;
         ciclo    <= '0;
         saidas_r <= '0;
      end else begin
         estado   <= estado_n;
         ciclo    <= ciclo_n;
         saidas_r <= decodificar(estado_n);
      end
   end

   assign estado_atual = estado;
   assign ciclo_atual  = ciclo;
   assign trava_porta  = saidas_r.trava_porta;
   assign concluido    = saidas_r.concluido;

`ifdef LAVADORA_PAUSA_EN
   assign valvula_agua  = saidas_r.valvula_agua  & ~congelado_c;
   assign valvula_dreno = saidas_r.valvula_dreno & ~congelado_c;
   assign modo_agitar   = saidas_r.modo_agitar   & ~congelado_c;
   assign modo_girar    = saidas_r.modo_girar    & ~congelado_c;
`else
   assign valvula_agua  = saidas_r.valvula_agua;
   assign valvula_dreno = saidas_r.valvula_dreno;
   assign modo_agitar   = saidas_r.modo_agitar;
   assign modo_girar    = saidas_r.modo_girar;
`endif

endmodule

// File: tb/tb_lavadora_programavel.sv
// Directed bench for lavadora_programavel (N_CICLOS=2, T_AGITAR=4, T_GIRAR=3).
// Pause scenario is exercised when LAVADORA_PAUSA_EN is defined, pause-ignored run otherwise.
module tb_lavadora_programavel;

   logic       clock   = 1'b0;
   logic       reset_n = 1'b0;
   logic       inicio  = 1'b0;
   logic       cheio   = 1'b0;
   logic       vazio   = 1'b0;
   logic       secar   = 1'b0;
   logic       pausa   = 1'b0;
   logic       valvula_agua;
   logic       valvula_dreno;
   logic       modo_agitar;
   logic       modo_girar;
   logic       trava_porta;
   logic       concluido;
   logic [2:0] estado_atual;
   logic [3:0] ciclo_atual;

   int total   = 0;
   int passou  = 0;

   always #5 clock = ~clock;

   lavadora_programavel #(
      .N_CICLOS (2),
      .TIMER_W  (8),
      .T_AGITAR (4),
      .T_GIRAR  (3)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .inicio        (inicio),
      .cheio         (cheio),
      .vazio         (vazio),
      .secar         (secar),
      .pausa         (pausa),
      .valvula_agua  (valvula_agua),
      .valvula_dreno (valvula_dreno),
      .modo_agitar   (modo_agitar),
      .modo_girar    (modo_girar),
      .trava_porta   (trava_porta),
      .concluido     (concluido),
      .estado_atual  (estado_atual),
      .ciclo_atual   (ciclo_atual)
   );

   // Expected {agua, dreno, agitar, girar, trava, concluido} for a state; p = frozen by pause
   function automatic logic [5:0] esperado(input logic [2:0] e, input logic p);
      logic [5:0] v;
      case (e)
         3'd1:    v = 6'b100010;
         3'd2:    v = 6'b001010;
         3'd3:    v = 6'b010010;
         3'd4:    v = 6'b000110;
         3'd5:    v = 6'b000011;
         default: v = 6'b000000;
      endcase
      if (p) v[5:2] = 4'b0000;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [2:0] e, input logic [3:0] c, input logic p);
      logic [5:0] obs;
      logic [5:0] exp_v;
      obs   = {valvula_agua, valvula_dreno, modo_agitar, modo_girar, trava_porta, concluido};
      exp_v = esperado(e, p);
      total++;
      assert (estado_atual === e) passou++;
      else $error("FAIL %s estado_atual observed=%0d expected=%0d", tag, estado_atual, e);
      total++;
      assert (ciclo_atual === c) passou++;
      else $error("FAIL %s ciclo_atual observed=%0d expected=%0d", tag, ciclo_atual, c);
      total++;
      assert (obs === exp_v) passou++;
      else $error("FAIL %s saidas observed=%b expected=%b", tag, obs, exp_v);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Two full cycles; sec selects final spin, pz holds pausa (must be ignored when not built)
   task automatic run_trace(input logic sec, input logic pz);
      pausa = pz;
      inicio = 1'b1; tick(); chk("trace_encher0", 3'd1, 4'd0, 1'b0);
      inicio = 1'b0;
      cheio = 1'b1;  tick(); chk("trace_agitar0_1", 3'd2, 4'd0, 1'b0);
      cheio = 1'b0;
      tick(); chk("trace_agitar0_2", 3'd2, 4'd0, 1'b0);
      tick(); chk("trace_agitar0_3", 3'd2, 4'd0, 1'b0);
      vazio = 1'b1;
      tick(); chk("trace_agitar0_4", 3'd2, 4'd0, 1'b0);
      tick(); chk("trace_drenar0", 3'd3, 4'd0, 1'b0);
      tick(); chk("trace_encher1", 3'd1, 4'd1, 1'b0);
      cheio = 1'b1;
      tick(); chk("trace_agitar1_1", 3'd2, 4'd1, 1'b0);
      cheio = 1'b0;
      tick(); chk("trace_agitar1_2", 3'd2, 4'd1, 1'b0);
      tick(); chk("trace_agitar1_3", 3'd2, 4'd1, 1'b0);
      secar = sec;
      tick(); chk("trace_agitar1_4", 3'd2, 4'd1, 1'b0);
      tick(); chk("trace_drenar1", 3'd3, 4'd1, 1'b0);
      if (sec) begin
         tick(); chk("trace_girar_1", 3'd4, 4'd1, 1'b0);
         vazio = 1'b0; secar = 1'b0;
         tick(); chk("trace_girar_2", 3'd4, 4'd1, 1'b0);
         tick(); chk("trace_girar_3", 3'd4, 4'd1, 1'b0);
      end
      tick(); chk("trace_fim", 3'd5, 4'd1, 1'b0);
      vazio = 1'b0; secar = 1'b0;
      tick(); chk("trace_esperar", 3'd0, 4'd1, 1'b0);
      tick(); chk("trace_esperar_fica", 3'd0, 4'd1, 1'b0);
      pausa = 1'b0;
   endtask

   initial begin
      #12;
      chk("reset_inicial", 3'd0, 4'd0, 1'b0);
      reset_n = 1'b1;
      tick(); chk("sem_inicio", 3'd0, 4'd0, 1'b0);

      run_trace(1'b1, 1'b0);
      run_trace(1'b0, 1'b0);

`ifdef LAVADORA_PAUSA_EN
      inicio = 1'b1; tick(); chk("pz_encher", 3'd1, 4'd0, 1'b0);
      inicio = 1'b0;
      cheio = 1'b1;  tick(); chk("pz_agitar_1", 3'd2, 4'd0, 1'b0);
      cheio = 1'b0;
      tick(); chk("pz_agitar_2", 3'd2, 4'd0, 1'b0);
      pausa = 1'b1;
      #1; chk("pz_imediato", 3'd2, 4'd0, 1'b1);
      repeat (5) begin
         tick(); chk("pz_congelado", 3'd2, 4'd0, 1'b1);
      end
      pausa = 1'b0;
      #1; chk("pz_retoma", 3'd2, 4'd0, 1'b0);
      tick(); chk("pz_agitar_3", 3'd2, 4'd0, 1'b0);
      tick(); chk("pz_agitar_4", 3'd2, 4'd0, 1'b0);
      tick(); chk("pz_drenar0", 3'd3, 4'd0, 1'b0);
      vazio = 1'b1;
      tick(); chk("pz_encher1", 3'd1, 4'd1, 1'b0);
      vazio = 1'b0; cheio = 1'b1;
      tick(); chk("pz_agitar1", 3'd2, 4'd1, 1'b0);
      cheio = 1'b0;
      repeat (3) tick();
      vazio = 1'b1;
      tick(); chk("pz_drenar1", 3'd3, 4'd1, 1'b0);
      tick(); chk("pz_fim", 3'd5, 4'd1, 1'b0);
      vazio = 1'b0;
      tick(); chk("pz_esperar", 3'd0, 4'd1, 1'b0);
`else
      run_trace(1'b1, 1'b1);
`endif

      // Reset in the middle of the spin phase
      inicio = 1'b1; tick(); chk("rst_encher", 3'd1, 4'd0, 1'b0);
      tick(); chk("rst_inicio_ignorado", 3'd1, 4'd0, 1'b0);
      inicio = 1'b0; cheio = 1'b1;
      tick(); chk("rst_agitar0", 3'd2, 4'd0, 1'b0);
      cheio = 1'b0;
      repeat (3) tick();
      tick(); chk("rst_drenar0", 3'd3, 4'd0, 1'b0);
      vazio = 1'b1;
      tick(); chk("rst_encher1", 3'd1, 4'd1, 1'b0);
      vazio = 1'b0; cheio = 1'b1;
      tick(); chk("rst_agitar1", 3'd2, 4'd1, 1'b0);
      cheio = 1'b0;
      repeat (3) tick();
      tick(); chk("rst_drenar1", 3'd3, 4'd1, 1'b0);
      vazio = 1'b1; secar = 1'b1;
      tick(); chk("rst_girar_1", 3'd4, 4'd1, 1'b0);
      vazio = 1'b0; secar = 1'b0;
      tick(); chk("rst_girar_2", 3'd4, 4'd1, 1'b0);
      #1 reset_n = 1'b0;
      #1 chk("rst_assincrono", 3'd0, 4'd0, 1'b0);
      tick(); chk("rst_mantido", 3'd0, 4'd0, 1'b0);
      #2 reset_n = 1'b1;
      tick(); chk("rst_liberado", 3'd0, 4'd0, 1'b0);
      inicio = 1'b1;
      tick(); chk("rst_reinicio", 3'd1, 4'd0, 1'b0);
      inicio = 1'b0;

      $display("%0d/%0d checks passed", passou, total);
      $finish;
   end

endmodule
